audio_sample_pwm: RTL and testbench

- Downstream consumer of the CMD18 multi-block read stage.
- Accepts 8-bit unsigned PCM bytes from the SD data stream into an elastic FIFO, then releases them at a fixed sample rate.
- Each released sample drives an 8-bit PWM modulator on the board audio pin (AUD_PWM).
- Decouples bursty SPI block reads (512-byte blocks plus CRC gaps) from constant-rate playback, and reports underruns and overflows.

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_sample_fifo.sv | 60 ++++++
 rtl/audio_sample_pwm.sv | 158 +++++++++++++++
 tb/tb_audio_sample_pwm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample PWM playback path.
package audio_pkg;

    localparam int unsigned PWM_BITS = 8;
    localparam logic [PWM_BITS-1:0] MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock elastic FIFO between the bursty SD read stream and constant-rate playback.
// Head byte is visible combinationally on dout; storage maps to distributed/block RAM.
module audio_sample_fifo #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_pwm.sv
// Buffers PCM bytes from the CMD18 read stage and plays them at a fixed rate through an 8-bit PWM.
// Optional build macro AUDIO_VOLUME_SHIFT_EN adds a Volume input that attenuates around midscale.
module audio_sample_pwm
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned SAMPLE_DIV  = 2268,
    parameter int unsigned PRIME_LEVEL = 512
) (
    input  logic                    Clock_100MHz,
    input  logic                    Clear,
    input  logic [7:0]              Sample_In,
    input  logic                    Sample_Valid,
    output logic                    Sample_Ready,
    input  logic                    Play_En,
`ifdef AUDIO_VOLUME_SHIFT_EN
    input  logic [1:0]              Volume,
`endif
    output logic                    AUD_PWM,
    output logic                    Playing,
    output logic [$clog2(DEPTH):0]  Fifo_Level,
    output logic [15:0]             Underrun_Count,
    output logic                    Overflow
);

    localparam int unsigned LW     = $clog2(DEPTH) + 1;
    localparam int unsigned TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

    state_t                 state;
    state_t                 state_next;
    logic [TICK_W-1:0]      tick_cnt;
    logic [TICK_W-1:0]      tick_next;
    logic [PWM_BITS-1:0]    duty;
    logic [PWM_BITS-1:0]    duty_next;
    logic [PWM_BITS-1:0]    duty_eff;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   tick;
    logic                   push;
    logic                   pop;
    logic                   underrun_hit;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PWM_BITS-1:0]    fifo_dout;
    logic [LW-1:0]          fifo_level;

    assign Sample_Ready = !fifo_full;
    assign push         = Sample_Valid && !fifo_full;
    assign tick         = (state == PLAY) && (tick_cnt == TICK_LAST);
    assign Fifo_Level   = fifo_level;

    audio_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PWM_BITS)
    ) u_fifo (
        .clk   (Clock_100MHz),
        .rst   (Clear),
        .push  (push),
        .pop   (pop),
        .din   (Sample_In),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge Clock_100MHz) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, sample tick, pop and duty selection; disabling playback wins over a coincident tick.
    always_comb begin
        state_next   = state;
        tick_next    = '0;
        duty_next    = duty;
        pop          = 1'b0;
        underrun_hit = 1'b0;
        case (state)
            IDLE: begin
                duty_next = MIDSCALE;
                if (Play_En) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (!Play_En) begin
                    state_next = IDLE;
                end else if (fifo_level >= LW'(PRIME_LEVEL)) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (!Play_En) begin
                    state_next = IDLE;
                    duty_next  = MIDSCALE;
                end else begin
                    tick_next = tick ? '0 : tick_cnt + TICK_W'(1);
                    if (tick) begin
                        if (fifo_empty) begin
                            duty_next    = MIDSCALE;
                            underrun_hit = 1'b1;
                        end else begin
                            pop       = 1'b1;
                            duty_next = fifo_dout;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                duty_next  = MIDSCALE;
            end
        endcase
    end

`ifdef AUDIO_VOLUME_SHIFT_EN
    logic signed [8:0] duty_delta;
    logic signed [8:0] duty_scaled;

    // Attenuate the excursion from midscale so silence stays silent at every volume.
    always_comb begin
        duty_delta  = $signed({1'b0, duty}) - 9'sd128;
        duty_scaled = duty_delta >>> Volume;
        duty_eff    = PWM_BITS'(duty_scaled + 9'sd128);
    end
`else
    assign duty_eff = duty;
`endif

    always_ff @(posedge Clock_100MHz) begin
        if (Clear) begin
            tick_cnt       <= '0;
            duty           <= MIDSCALE;
            pwm_cnt        <= '0;
            AUD_PWM        <= 1'b0;
            Playing        <= 1'b0;
            Underrun_Count <= '0;
            Overflow       <= 1'b0;
        end else begin
            tick_cnt <= tick_next;
            duty     <= duty_next;
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            AUD_PWM  <= (pwm_cnt < duty_eff);
            Playing  <= (state_next == PLAY);
            if (underrun_hit && (Underrun_Count != 16'hFFFF)) begin
                Underrun_Count <= Underrun_Count + 16'd1;
            end
            if (Sample_Valid && fifo_full) begin
                Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_pwm.sv
// Self-checking bench: a full-size instance for priming, duty, overflow and disable behaviour,
// plus a tiny fast-tick instance that exercises underrun counting through saturation.
module tb_audio_sample_pwm;
    import audio_pkg::*;

    localparam int SD = 2268;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Full-size instance
    logic        clear, valid, play_en, ready, aud, playing, overflow;
    logic [7:0]  din;
    logic [10:0] level;
    logic [15:0] underruns;

    // Small instance: DEPTH 8, tick every clock, prime at 3 bytes
    logic        s_clear, s_valid, s_play, s_ready, s_aud, s_playing, s_overflow;
    logic [7:0]  s_din;
    logic [3:0]  s_level;
    logic [15:0] s_underruns;

`ifdef AUDIO_VOLUME_SHIFT_EN
    logic [1:0] volume = 2'd0;
`endif

    audio_sample_pwm dut (
        .Clock_100MHz   (clk),
        .Clear          (clear),
        .Sample_In      (din),
        .Sample_Valid   (valid),
        .Sample_Ready   (ready),
        .Play_En        (play_en),
`ifdef AUDIO_VOLUME_SHIFT_EN
        .Volume         (volume),
`endif
        .AUD_PWM        (aud),
        .Playing        (playing),
        .Fifo_Level     (level),
        .Underrun_Count (underruns),
        .Overflow       (overflow)
    );

    audio_sample_pwm #(
        .DEPTH       (8),
        .SAMPLE_DIV  (1),
        .PRIME_LEVEL (3)
    ) dut_s (
        .Clock_100MHz   (clk),
        .Clear          (s_clear),
        .Sample_In      (s_din),
        .Sample_Valid   (s_valid),
        .Sample_Ready   (s_ready),
        .Play_En        (s_play),
`ifdef AUDIO_VOLUME_SHIFT_EN
        .Volume         (volume),
`endif
        .AUD_PWM        (s_aud),
        .Playing        (s_playing),
        .Fifo_Level     (s_level),
        .Underrun_Count (s_underruns),
        .Overflow       (s_overflow)
    );

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] s_q[$];
    int lvl;
    int p;
    int c_u;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cycle < c) cyc();
    endtask

    function automatic logic [7:0] prime_byte(input int i);
        if (i == 0) return 8'h00;
        if (i == 1) return 8'hFF;
        if (i == 2) return 8'h40;
        return 8'(i * 7 + 3);
    endfunction

    task automatic test_reset();
        int highs;
        clear = 1'b1; s_clear = 1'b1; valid = 1'b1; s_valid = 1'b1;
        din = 8'h55; s_din = 8'h55; play_en = 1'b0; s_play = 1'b0;
        repeat (3) cyc();
        checks++; if (aud !== 1'b0) begin fails++; $display("FAIL reset_aud: got %0b want 0", aud); end
        checks++; if (playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %0b want 0", playing); end
        checks++; if (level !== 11'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (underruns !== 16'd0) begin fails++; $display("FAIL reset_underruns: got %0d want 0", underruns); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        clear = 1'b0; s_clear = 1'b0; valid = 1'b0; s_valid = 1'b0;
        cyc();
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %0b want 1", ready); end
        checks++; if (level !== 11'd0) begin fails++; $display("FAIL release_level: got %0d want 0", level); end
        highs = 0;
        repeat (256) begin cyc(); if (aud === 1'b1) highs++; end
        checks++; if (highs != 128) begin fails++; $display("FAIL idle_pwm_highs: got %0d want 128", highs); end
    endtask

    task automatic test_underrun();
        logic [7:0] e;
        s_play = 1'b1; s_valid = 1'b1;
        s_din = 8'h11; s_q.push_back(s_din); cyc();
        s_din = 8'h22; s_q.push_back(s_din); cyc();
        s_din = 8'h33; s_q.push_back(s_din); cyc();
        s_valid = 1'b0;
        checks++; if (s_playing !== 1'b0) begin fails++; $display("FAIL ur_fill_playing: got %0b want 0", s_playing); end
        checks++; if (s_level !== 4'd3) begin fails++; $display("FAIL ur_fill_level: got %0d want 3", s_level); end
        cyc();
        checks++; if (s_playing !== 1'b1) begin fails++; $display("FAIL ur_playing: got %0b want 1", s_playing); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            e = s_q.pop_front();
            checks++; if (dut_s.duty !== e) begin fails++; $display("FAIL ur_duty%0d: got %h want %h", k, dut_s.duty, e); end
            checks++; if (s_level !== 4'(2 - k)) begin fails++; $display("FAIL ur_level%0d: got %0d want %0d", k, s_level, 2 - k); end
        end
        cyc();
        checks++; if (s_underruns !== 16'd1) begin fails++; $display("FAIL ur_count1: got %0d want 1", s_underruns); end
        cyc();
        checks++; if (s_underruns !== 16'd2) begin fails++; $display("FAIL ur_count2: got %0d want 2", s_underruns); end
        checks++; if (dut_s.duty !== 8'h80) begin fails++; $display("FAIL ur_silence: got %h want 80", dut_s.duty); end
        c_u = cycle;
    endtask

    task automatic test_prime();
        play_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            if (i == 511) begin
                checks++; if (playing !== 1'b0) begin fails++; $display("FAIL prime511_playing: got %0b want 0", playing); end
                checks++; if (level !== 11'd511) begin fails++; $display("FAIL prime511_level: got %0d want 511", level); end
            end
            valid = 1'b1; din = prime_byte(i); exp_q.push_back(din);
            cyc();
        end
        valid = 1'b0; lvl = 512;
        checks++; if (level !== 11'd512) begin fails++; $display("FAIL prime_level: got %0d want 512", level); end
        cyc();
        checks++; if (playing !== 1'b1) begin fails++; $display("FAIL prime_playing: got %0b want 1", playing); end
        p = cycle;
        wait_until(p + SD - 1);
        checks++; if (level !== 11'd512) begin fails++; $display("FAIL prepop_level: got %0d want 512", level); end
    endtask

    task automatic test_duty_values();
        int highs;
        logic [7:0] e;
        for (int k = 1; k <= 3; k++) begin
            wait_until(p + k * SD);
            e = exp_q.pop_front(); lvl--;
            checks++; if (dut.duty !== e) begin fails++; $display("FAIL duty%0d: got %h want %h", k, dut.duty, e); end
            checks++; if (level !== 11'(lvl)) begin fails++; $display("FAIL pop_level%0d: got %0d want %0d", k, level, lvl); end
            highs = 0;
            repeat (256) begin cyc(); if (aud === 1'b1) highs++; end
            checks++; if (highs != int'(e)) begin fails++; $display("FAIL pwm_highs%0d: got %0d want %0d", k, highs, e); end
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] e;
        for (int j = 0; lvl < 1024; j++) begin
            valid = 1'b1; din = 8'(j) ^ 8'h5A; exp_q.push_back(din);
            cyc(); lvl++;
        end
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %0b want 0", ready); end
        checks++; if (level !== 11'd1024) begin fails++; $display("FAIL full_level: got %0d want 1024", level); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_no_overflow: got %0b want 0", overflow); end
        din = 8'hAA;
        repeat (4) cyc();
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %0b want 1", overflow); end
        checks++; if (level !== 11'd1024) begin fails++; $display("FAIL overflow_level: got %0d want 1024", level); end
        wait_until(p + 4 * SD);
        e = exp_q.pop_front();
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL pop_ready: got %0b want 1", ready); end
        checks++; if (level !== 11'd1023) begin fails++; $display("FAIL pop_level_full: got %0d want 1023", level); end
        checks++; if (dut.duty !== e) begin fails++; $display("FAIL duty4: got %h want %h", dut.duty, e); end
        exp_q.push_back(8'hAA);
        cyc();
        valid = 1'b0;
        checks++; if (level !== 11'd1024) begin fails++; $display("FAIL refill_level: got %0d want 1024", level); end
        checks++; if (ready !== 1'b0) begin fails++; $display("FAIL refill_ready: got %0b want 0", ready); end
        checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_disable();
        int highs;
        logic [7:0] e;
        wait_until(p + 4 * SD + 1000);
        play_en = 1'b0;
        cyc();
        checks++; if (playing !== 1'b0) begin fails++; $display("FAIL dis_playing: got %0b want 0", playing); end
        checks++; if (dut.duty !== 8'h80) begin fails++; $display("FAIL dis_duty: got %h want 80", dut.duty); end
        checks++; if (dut.tick_cnt !== '0) begin fails++; $display("FAIL dis_tick: got %0d want 0", dut.tick_cnt); end
        checks++; if (level !== 11'd1024) begin fails++; $display("FAIL dis_level: got %0d want 1024", level); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL dis_state: got %0d want IDLE", dut.state); end
        highs = 0;
        repeat (256) begin cyc(); if (aud === 1'b1) highs++; end
        checks++; if (highs != 128) begin fails++; $display("FAIL dis_pwm_highs: got %0d want 128", highs); end
        play_en = 1'b1;
        cyc();
        checks++; if (dut.state !== FILL) begin fails++; $display("FAIL reen_state: got %0d want FILL", dut.state); end
        checks++; if (playing !== 1'b0) begin fails++; $display("FAIL reen_fill_playing: got %0b want 0", playing); end
        cyc();
        checks++; if (playing !== 1'b1) begin fails++; $display("FAIL reen_playing: got %0b want 1", playing); end
        p = cycle;
        wait_until(p + SD - 1);
        checks++; if (level !== 11'd1024) begin fails++; $display("FAIL reen_prepop_level: got %0d want 1024", level); end
        wait_until(p + SD);
        e = exp_q.pop_front();
        checks++; if (level !== 11'd1023) begin fails++; $display("FAIL reen_pop_level: got %0d want 1023", level); end
        checks++; if (dut.duty !== e) begin fails++; $display("FAIL reen_duty: got %h want %h", dut.duty, e); end
    endtask

    task automatic test_clear_in_play();
        clear = 1'b1;
        cyc();
        clear = 1'b0; play_en = 1'b0;
        exp_q.delete();
        checks++; if (level !== 11'd0) begin fails++; $display("FAIL clr_level: got %0d want 0", level); end
        checks++; if (playing !== 1'b0) begin fails++; $display("FAIL clr_playing: got %0b want 0", playing); end
        checks++; if (dut.state !== IDLE) begin fails++; $display("FAIL clr_state: got %0d want IDLE", dut.state); end
        checks++; if (ready !== 1'b1) begin fails++; $display("FAIL clr_ready: got %0b want 1", ready); end
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_overflow: got %0b want 0", overflow); end
        checks++; if (underruns !== 16'd0) begin fails++; $display("FAIL clr_underruns: got %0d want 0", underruns); end
        checks++; if (aud !== 1'b0) begin fails++; $display("FAIL clr_aud: got %0b want 0", aud); end
        checks++; if (dut.duty !== 8'h80) begin fails++; $display("FAIL clr_duty: got %h want 80", dut.duty); end
    endtask

    task automatic test_saturation();
        int want;
        want = 2 + (cycle - c_u);
        checks++; if (s_underruns !== 16'(want)) begin fails++; $display("FAIL sat_mid: got %0d want %0d", s_underruns, want); end
        wait_until(c_u + 65532);
        checks++; if (s_underruns !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %h want fffe", s_underruns); end
        cyc();
        checks++; if (s_underruns !== 16'hFFFF) begin fails++; $display("FAIL sat_hit: got %h want ffff", s_underruns); end
        repeat (50) cyc();
        checks++; if (s_underruns !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %h want ffff", s_underruns); end
        checks++; if (s_playing !== 1'b1) begin fails++; $display("FAIL sat_playing: got %0b want 1", s_playing); end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_prime();
        test_duty_values();
        test_full_overflow();
        test_disable();
        test_clear_in_play();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
        $fatal(1, "timeout");
    end

endmodule
